parity_framer: RTL and testbench

PARITY_FRAMER -- requirements
Module: parity_framer

---
 rtl/parity_framer.sv | 193 +++++++++++++++++++
 tb/tb_parity_framer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/parity_framer.sv
// parity_framer: serial frame transmitter (start, LSB-first data, optional
// parity, 1 or 2 stop bits). One bit period per clock cycle; all outputs
// are registered.
// Optional feature: define PARITY_ERR_INJECT_EN to add the Err_inject input,
// which inverts the transmitted parity slot of the accepted frame while the
// Par_bit output keeps the true parity.

module parity_framer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Data_valid,
  input  logic [DATA_WIDTH-1:0] P_data,
  input  logic                  Par_en,
  input  logic [1:0]            Par_mode,
`ifdef PARITY_ERR_INJECT_EN
  input  logic                  Err_inject,
`endif
  output logic                  TX_OUT,
  output logic                  Busy,
  output logic                  Par_bit,
  output logic                  Frame_done
);

  localparam int unsigned       CNT_W     = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
  localparam logic              LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic                    stop_cnt_q, stop_cnt_d;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    par_en_q;
  logic                    inj_q;
  logic                    accept;
  logic                    par_calc;
  logic                    tx_d, busy_d, done_d;

  // A request is only looked at while idle
  assign accept = (state_q == IDLE) && Data_valid;

  // Parity of the incoming payload for the requested mode; the latched
  // result carries the mode for the rest of the frame
  always_comb begin
    par_calc = 1'b0;
    case (Par_mode)
      2'b00:   par_calc = ^P_data;
      2'b01:   par_calc = ~^P_data;
      2'b10:   par_calc = 1'b1;
      default: par_calc = 1'b0;
    endcase
  end

  // State and counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
    end
  end

  // Next-state sequencing; counters are cleared on leaving their phase so
  // the bit counter never runs past the last data bit
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    case (state_q)
      IDLE: begin
        bit_cnt_d  = '0;
        stop_cnt_d = 1'b0;
        if (Data_valid) state_d = START;
      end
      START: begin
        bit_cnt_d = '0;
        state_d   = DATA;
      end
      DATA: begin
        if (bit_cnt_q == LAST_BIT) begin
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
          state_d    = par_en_q ? PARITY : STOP;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      PARITY: begin
        stop_cnt_d = 1'b0;
        state_d    = STOP;
      end
      STOP: begin
        if (stop_cnt_q == LAST_STOP) begin
          stop_cnt_d = 1'b0;
          state_d    = IDLE;
        end else begin
          stop_cnt_d = stop_cnt_q + 1'b1;
        end
      end
      default: begin
        bit_cnt_d  = '0;
        stop_cnt_d = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end

  // Latch the frame request; Par_bit only moves when parity is enabled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q   <= '0;
      par_en_q <= 1'b0;
      Par_bit  <= 1'b0;
    end else if (accept) begin
      data_q   <= P_data;
      par_en_q <= Par_en;
      if (Par_en) Par_bit <= par_calc;
    end
  end

`ifdef PARITY_ERR_INJECT_EN
  // Capture the parity-corruption request with the frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inj_q <= 1'b0;
    end else if (accept) begin
      inj_q <= Err_inject;
    end
  end
`else
  assign inj_q = 1'b0;
`endif

  // Output decode from the upcoming state so the registered line matches
  // the state it belongs to
  always_comb begin
    tx_d   = 1'b1;
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_d)
      START: begin
        tx_d   = 1'b0;
        busy_d = 1'b1;
      end
      DATA: begin
        tx_d   = data_q[bit_cnt_d];
        busy_d = 1'b1;
      end
      PARITY: begin
        tx_d   = Par_bit ^ inj_q;
        busy_d = 1'b1;
      end
      STOP: begin
        tx_d   = 1'b1;
        busy_d = 1'b1;
        done_d = (stop_cnt_d == LAST_STOP);
      end
      default: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        done_d = 1'b0;
      end
    endcase
  end

  // Output registers; reset forces the line high at once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      TX_OUT     <= 1'b1;
      Busy       <= 1'b0;
      Frame_done <= 1'b0;
    end else begin
      TX_OUT     <= tx_d;
      Busy       <= busy_d;
      Frame_done <= done_d;
    end
  end

endmodule

// File: tb/tb_parity_framer.sv
// tb_parity_framer: table-driven frames checked by a bit-level scoreboard,
// plus hand sequences for back-to-back requests, mid-frame reset and a
// two-stop-bit instance.

module tb_parity_framer;

  logic       clk;
  logic       rst;
  logic       dv, pe;
  logic [7:0] pd;
  logic [1:0] pm;
  logic       tx, busy, pb, fd;
  logic       dv2, pe2;
  logic [7:0] pd2;
  logic [1:0] pm2;
  logic       tx2, busy2, pb2, fd2;
`ifdef PARITY_ERR_INJECT_EN
  logic       err, err2;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 0;

  typedef struct {
    logic tx;
    logic done;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [7:0] data;
    logic       en;
    logic [1:0] mode;
    logic       exp_par;
  } vec_t;
  vec_t tbl[10];

  parity_framer #(.DATA_WIDTH(8), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst), .Data_valid(dv), .P_data(pd), .Par_en(pe),
    .Par_mode(pm),
`ifdef PARITY_ERR_INJECT_EN
    .Err_inject(err),
`endif
    .TX_OUT(tx), .Busy(busy), .Par_bit(pb), .Frame_done(fd)
  );

  parity_framer #(.DATA_WIDTH(8), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .Data_valid(dv2), .P_data(pd2), .Par_en(pe2),
    .Par_mode(pm2),
`ifdef PARITY_ERR_INJECT_EN
    .Err_inject(err2),
`endif
    .TX_OUT(tx2), .Busy(busy2), .Par_bit(pb2), .Frame_done(fd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Expected line bits for one frame on the one-stop-bit instance
  task automatic push_frame(input logic [7:0] d, input logic en, input logic slot);
    exp_q.push_back('{tx: 1'b0, done: 1'b0});
    for (int i = 0; i < 8; i++) exp_q.push_back('{tx: d[i], done: 1'b0});
    if (en) exp_q.push_back('{tx: slot, done: 1'b0});
    exp_q.push_back('{tx: 1'b1, done: 1'b1});
  endtask

  // Count busy cycles of the running frame, then check its results
  task automatic wait_frame(input int len, input logic ep);
    int n;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      if (!busy) break;
      n++;
      @(negedge clk);
    end
    check("frame_len", 32'(n), 32'(len));
    check("par_bit", 32'(pb), 32'(ep));
    check("sb_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic send(input logic [7:0] d, input logic en, input logic [1:0] m,
                      input logic ep, input logic inj);
    @(negedge clk);
    push_frame(d, en, ep ^ inj);
    dv = 1'b1; pd = d; pe = en; pm = m;
`ifdef PARITY_ERR_INJECT_EN
    err = inj;
`endif
    @(negedge clk);
    dv = 1'b0; pd = 8'($urandom); pe = 1'($urandom); pm = 2'($urandom);
`ifdef PARITY_ERR_INJECT_EN
    err = 1'($urandom);
`endif
    wait_frame(en ? 11 : 10, ep);
  endtask

  // Scoreboard: every busy cycle consumes one expected line bit
  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en) begin
      if (busy) begin
        if (exp_q.size() == 0) begin
          check("busy_extra", 32'(busy), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("tx_out", 32'(tx), 32'(e.tx));
          check("frame_done", 32'(fd), 32'(e.done));
        end
      end else begin
        check("idle_tx", 32'(tx), 32'd1);
        check("idle_done", 32'(fd), 32'd0);
      end
    end
  end

  initial begin
    int b2_n, d2_n, d2_at;
    logic tx2_first, tx2_rest_ok;

    tbl[0] = '{8'hA5, 1'b1, 2'b00, 1'b0};
    tbl[1] = '{8'h01, 1'b1, 2'b01, 1'b0};
    tbl[2] = '{8'h01, 1'b1, 2'b10, 1'b1};
    tbl[3] = '{8'h01, 1'b1, 2'b11, 1'b0};
    tbl[4] = '{8'h07, 1'b1, 2'b00, 1'b1};
    tbl[5] = '{8'h07, 1'b1, 2'b01, 1'b0};
    tbl[6] = '{8'h3C, 1'b0, 2'b10, 1'b0};
    tbl[7] = '{8'hFF, 1'b1, 2'b01, 1'b1};
    tbl[8] = '{8'h00, 1'b0, 2'b00, 1'b1};
    tbl[9] = '{8'h80, 1'b1, 2'b00, 1'b1};

    rst = 1'b0;
    dv = 1'b0; pd = '0; pe = 1'b0; pm = '0;
    dv2 = 1'b0; pd2 = '0; pe2 = 1'b0; pm2 = '0;
`ifdef PARITY_ERR_INJECT_EN
    err = 1'b0; err2 = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_par_bit", 32'(pb), 32'd0);
    check("rst_done", 32'(fd), 32'd0);
    rst = 1'b1;
    mon_en = 1;

    for (int i = 0; i < 10; i++)
      send(tbl[i].data, tbl[i].en, tbl[i].mode, tbl[i].exp_par, 1'b0);

    // Request held high, payload changed mid-frame
    @(negedge clk);
    push_frame(8'h3C, 1'b1, 1'b0);
    push_frame(8'hC3, 1'b1, 1'b1);
    dv = 1'b1; pd = 8'h3C; pe = 1'b1; pm = 2'b00;
`ifdef PARITY_ERR_INJECT_EN
    err = 1'b0;
`endif
    @(negedge clk);
    pd = 8'hC3; pm = 2'b10;
    repeat (11) @(negedge clk);
    check("gap_idle", 32'(busy), 32'd0);
    @(negedge clk);
    check("gap_restart", 32'(busy), 32'd1);
    dv = 1'b0;
    wait_frame(11, 1'b1);

    // Reset during data bit 3 aborts the frame
    mon_en = 0;
    @(negedge clk);
    dv = 1'b1; pd = 8'h00; pe = 1'b1; pm = 2'b00;
    @(negedge clk);
    dv = 1'b0;
    repeat (4) @(negedge clk);
    check("bit3_low", 32'(tx), 32'd0);
    #2 rst = 1'b0;
    #1;
    check("abort_tx", 32'(tx), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_par_bit", 32'(pb), 32'd0);
    check("abort_done", 32'(fd), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_hold_done", 32'(fd), 32'd0);
      check("rst_hold_tx", 32'(tx), 32'd1);
    end
    exp_q.delete();
    push_frame(8'hA5, 1'b1, 1'b1);
    dv = 1'b1; pd = 8'hA5; pe = 1'b1; pm = 2'b01;
    mon_en = 1;
    rst = 1'b1;
    @(negedge clk);
    dv = 1'b0;
    wait_frame(11, 1'b1);

    // Two stop bits, parity disabled
    @(negedge clk);
    dv2 = 1'b1; pd2 = 8'hFF; pe2 = 1'b0; pm2 = 2'b00;
    @(negedge clk);
    dv2 = 1'b0; pd2 = 8'h00; pe2 = 1'b1;
    b2_n = 0; d2_n = 0; d2_at = 0; tx2_first = 1'b1; tx2_rest_ok = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      if (busy2) b2_n++;
      if (fd2) begin d2_n++; d2_at = c; end
      if (c == 1) tx2_first = tx2;
      else if (tx2 !== 1'b1) tx2_rest_ok = 1'b0;
      @(negedge clk);
    end
    check("sb2_busy_cycles", 32'(b2_n), 32'd11);
    check("sb2_done_count", 32'(d2_n), 32'd1);
    check("sb2_done_cycle", 32'(d2_at), 32'd11);
    check("sb2_start_bit", 32'(tx2_first), 32'd0);
    check("sb2_line_high", 32'(tx2_rest_ok), 32'd1);
    check("sb2_par_bit", 32'(pb2), 32'd0);

`ifdef PARITY_ERR_INJECT_EN
    send(8'hA5, 1'b1, 2'b00, 1'b0, 1'b1);
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
